pc_rx_rr_arbit: RTL and testbench

Parametrised N-user round-robin read arbiter for the PC-receive frame-data BRAM. It grants one user at a time exclusive ownership of the single BRAM read port and routes that user's address and read enable to the RAM. Returned data carries a per-user valid aligned to the BRAM read latency. A watchdog releases a grant whose owner never signals done. It sits between the PC-receive frame parsers and the shared frame-data BRAM, in the PC transfer receive path.

---
 rtl/pc_rx_pkg.sv | 15 +
 rtl/pc_rx_rr_pick.sv | 34 +++
 rtl/pc_rx_rr_arbit.sv | 174 +++++++++++++++++
 tb/tb_pc_rx_rr_arbit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_rx_pkg.sv
// Shared definitions for the PC-receive frame-data read path.
// Holds the arbiter FSM state encoding, the user-count ceiling and the
// width of the grant index carried on arb_grant_id.
package pc_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARBIT = 2'b01,
      RDRAM = 2'b11
   } arb_state_t;

   localparam int unsigned NUM_USER_MAX = 8;
   localparam int unsigned GID_W        = 3;

endpackage

// File: rtl/pc_rx_rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector starting one past last_grant, wrapping modulo
// NUM_USER, and returns the first requester found.
//   req        : per-user request level
//   last_grant : index of the previous owner
//   grant      : selected user index (0 when nothing is requested)
//   any_req    : at least one request is pending
module pc_rx_rr_pick
   import pc_rx_pkg::*;
#(
   parameter int unsigned NUM_USER = 4
) (
   input  logic [NUM_USER-1:0] req,
   input  logic [GID_W-1:0]    last_grant,
   output logic [GID_W-1:0]    grant,
   output logic                any_req
);

   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      // Offset 1 is tested first, so the earliest offset with a request wins.
      for (int unsigned ofs = 1; ofs <= NUM_USER; ofs++) begin
         for (int unsigned k = 0; k < NUM_USER; k++) begin
            if (!any_req && req[k] &&
                (((32'(last_grant) + ofs) % NUM_USER) == k)) begin
               grant   = GID_W'(k);
               any_req = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pc_rx_rr_arbit.sv
// N-user round-robin read arbiter for the PC-receive frame-data BRAM.
// One user at a time owns the single BRAM read port; its address and read
// strobe are routed to the RAM and returned data is tagged with a per-user
// valid delayed by the BRAM read latency. A watchdog reclaims a grant whose
// owner never releases it.
//   clk_sys, rst_n    : system clock, asynchronous active-low reset
//   usr_rd_req/ack    : per-user request level / registered acknowledge
//   usr_rd_done       : per-user release pulse (owner only)
//   usr_rd_en/addr    : per-user read strobe and address
//   usr_rd_data/vld   : broadcast read data, per-user data valid
//   mux_ram_rd_*      : BRAM read port
//   arb_busy          : a grant is active (RDRAM)
//   arb_grant_id      : current / last granted user
//   arb_tmo           : one-cycle pulse when the watchdog releases a grant
module pc_rx_rr_arbit
   import pc_rx_pkg::*;
#(
   parameter int          U_DLY    = 1,
   parameter int unsigned NUM_USER = 4,
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned TMO_MAX  = 4096
) (
   input  logic                         clk_sys,
   input  logic                         rst_n,
   input  logic [NUM_USER-1:0]          usr_rd_req,
   output logic [NUM_USER-1:0]          usr_rd_ack,
   input  logic [NUM_USER-1:0]          usr_rd_done,
   input  logic [NUM_USER-1:0]          usr_rd_en,
   input  logic [NUM_USER*ADDR_W-1:0]   usr_rd_addr,
   output logic [DATA_W-1:0]            usr_rd_data,
   output logic [NUM_USER-1:0]          usr_rd_vld,
   output logic                         mux_ram_rd_en,
   output logic [ADDR_W-1:0]            mux_ram_rd_addr,
   input  logic [DATA_W-1:0]            mux_ram_rd_data,
   output logic                         arb_busy,
   output logic [GID_W-1:0]             arb_grant_id,
   output logic                         arb_tmo
);

   localparam int unsigned TMO_W = (TMO_MAX > 0) ? $clog2(TMO_MAX + 1) : 1;

   // U_DLY is kept for instantiation compatibility; registers here carry no delay.
   if (NUM_USER < 2 || NUM_USER > NUM_USER_MAX || RD_LAT < 1 || RD_LAT > 3 ||
       U_DLY < 0) begin : g_param_chk
      $error("pc_rx_rr_arbit: parameter out of range");
   end

   arb_state_t           state;
   logic [GID_W-1:0]     grant;
   logic [GID_W-1:0]     last_grant;
   logic [GID_W-1:0]     pick_id;
   logic                 pick_any;
   logic [TMO_W-1:0]     tmo_cnt;
   logic                 tmo_hit;

   logic [NUM_USER-1:0]  grant_sel;
   logic [NUM_USER-1:0]  ack_nxt;
   logic [ADDR_W-1:0]    grant_addr;
   logic                 grant_en;
   logic                 grant_req;
   logic                 grant_done;

   logic [RD_LAT-1:0]    pipe_en;
   logic [GID_W-1:0]     pipe_id [RD_LAT];

   pc_rx_rr_pick #(
      .NUM_USER (NUM_USER)
   ) u_pick (
      .req        (usr_rd_req),
      .last_grant (last_grant),
      .grant      (pick_id),
      .any_req    (pick_any)
   );

   // Owner-side select; an index outside 0..NUM_USER-1 falls back to user 0.
   always_comb begin
      grant_sel    = '0;
      grant_sel[0] = 1'b1;
      grant_addr   = usr_rd_addr[ADDR_W-1:0];
      grant_en     = usr_rd_en[0];
      grant_req    = usr_rd_req[0];
      grant_done   = usr_rd_done[0];
      for (int unsigned k = 1; k < NUM_USER; k++) begin
         if (grant == GID_W'(k)) begin
            grant_sel    = '0;
            grant_sel[k] = 1'b1;
            grant_addr   = usr_rd_addr[k*ADDR_W +: ADDR_W];
            grant_en     = usr_rd_en[k];
            grant_req    = usr_rd_req[k];
            grant_done   = usr_rd_done[k];
         end
      end
   end

   assign ack_nxt         = (state == RDRAM && grant_req) ? grant_sel : '0;
   assign tmo_hit         = (TMO_MAX != 0) && (tmo_cnt == TMO_W'(TMO_MAX - 1));
   assign mux_ram_rd_addr = grant_addr;
   assign mux_ram_rd_en   = grant_en && (state == RDRAM);
   assign arb_busy        = (state == RDRAM);
   assign arb_grant_id    = grant;
   assign usr_rd_data     = mux_ram_rd_data;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= GID_W'(NUM_USER - 1);
         tmo_cnt    <= '0;
         usr_rd_ack <= '0;
         arb_tmo    <= 1'b0;
      end else begin
         arb_tmo    <= 1'b0;
         usr_rd_ack <= ack_nxt;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               state   <= ARBIT;
            end
            ARBIT: begin
               tmo_cnt <= '0;
               if (pick_any) begin
                  grant      <= pick_id;
                  last_grant <= pick_id;
                  state      <= RDRAM;
               end
            end
            RDRAM: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               // A release on the last watchdog cycle is a normal release.
               if (grant_done) begin
                  state <= ARBIT;
               end else if (tmo_hit) begin
                  state   <= ARBIT;
                  arb_tmo <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-return tags; entries in flight finish even after the grant moves on.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pipe_en <= '0;
         for (int unsigned s = 0; s < RD_LAT; s++) begin
            pipe_id[s] <= '0;
         end
      end else begin
         pipe_en[0] <= mux_ram_rd_en;
         pipe_id[0] <= grant;
         for (int unsigned s = 1; s < RD_LAT; s++) begin
            pipe_en[s] <= pipe_en[s-1];
            pipe_id[s] <= pipe_id[s-1];
         end
      end
   end

   always_comb begin
      usr_rd_vld = '0;
      if (pipe_en[RD_LAT-1]) begin
         usr_rd_vld[0] = 1'b1;
         for (int unsigned k = 1; k < NUM_USER; k++) begin
            if (pipe_id[RD_LAT-1] == GID_W'(k)) begin
               usr_rd_vld    = '0;
               usr_rd_vld[k] = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_rx_rr_arbit.sv
module tb_pc_rx_rr_arbit;

   logic        clk_sys = 1'b0;
   logic        rst_n   = 1'b0;
   logic [3:0]  usr_rd_req  = '0;
   logic [3:0]  usr_rd_ack;
   logic [3:0]  usr_rd_done = '0;
   logic [3:0]  usr_rd_en   = '0;
   logic [47:0] usr_rd_addr = {12'h423, 12'h323, 12'h223, 12'h123};
   logic [7:0]  usr_rd_data;
   logic [3:0]  usr_rd_vld;
   logic        mux_ram_rd_en;
   logic [11:0] mux_ram_rd_addr;
   logic [7:0]  mux_ram_rd_data;
   logic        arb_busy;
   logic [2:0]  arb_grant_id;
   logic        arb_tmo;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [3:0] vld;
      logic [7:0] data;
      int         cyc;
   } rd_exp_t;

   logic [2:0] exp_grant_q [$];
   logic [3:0] exp_ack_q   [$];
   rd_exp_t    exp_rd_q    [$];
   int         exp_tmo_q   [$];

   pc_rx_rr_arbit #(
      .U_DLY    (1),
      .NUM_USER (4),
      .ADDR_W   (12),
      .DATA_W   (8),
      .RD_LAT   (2),
      .TMO_MAX  (16)
   ) dut (
      .clk_sys         (clk_sys),
      .rst_n           (rst_n),
      .usr_rd_req      (usr_rd_req),
      .usr_rd_ack      (usr_rd_ack),
      .usr_rd_done     (usr_rd_done),
      .usr_rd_en       (usr_rd_en),
      .usr_rd_addr     (usr_rd_addr),
      .usr_rd_data     (usr_rd_data),
      .usr_rd_vld      (usr_rd_vld),
      .mux_ram_rd_en   (mux_ram_rd_en),
      .mux_ram_rd_addr (mux_ram_rd_addr),
      .mux_ram_rd_data (mux_ram_rd_data),
      .arb_busy        (arb_busy),
      .arb_grant_id    (arb_grant_id),
      .arb_tmo         (arb_tmo)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Two-cycle BRAM model: data = addr[7:0] ^ 8'h5A.
   logic [7:0] ram_s1 = '0;
   logic [7:0] ram_s2 = '0;
   always @(posedge clk_sys) begin
      if (mux_ram_rd_en) ram_s1 <= mux_ram_rd_addr[7:0] ^ 8'h5A;
      ram_s2 <= ram_s1;
   end
   assign mux_ram_rd_data = ram_s2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      checks++;
      failures++;
      $display("FAIL %s: actual=0x%0h required=no event (cycle %0d)", name, act, cyc);
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_ack(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_sys);
         if (usr_rd_ack != '0) seen = 1'b1;
         else tick();
      end
      chk(name, 64'(seen), 64'd1);
   endtask

   task automatic do_reset();
      tick();
      rst_n       = 1'b0;
      usr_rd_req  = '0;
      usr_rd_done = '0;
      usr_rd_en   = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
   endtask

   // Monitor: pops expectations whenever the DUT presents an event.
   logic       prev_busy = 1'b0;
   logic [3:0] prev_ack  = '0;
   initial begin
      forever begin
         @(negedge clk_sys);
         if (arb_busy && !prev_busy) begin
            if (exp_grant_q.size() == 0) unexpected("grant_event", 64'(arb_grant_id));
            else chk("grant_id", 64'(arb_grant_id), 64'(exp_grant_q.pop_front()));
         end
         if (usr_rd_ack != '0 && usr_rd_ack != prev_ack) begin
            if (exp_ack_q.size() == 0) unexpected("ack_event", 64'(usr_rd_ack));
            else chk("ack_value", 64'(usr_rd_ack), 64'(exp_ack_q.pop_front()));
         end
         if (usr_rd_vld != '0) begin
            if (exp_rd_q.size() == 0) unexpected("vld_event", 64'(usr_rd_vld));
            else begin
               rd_exp_t e;
               e = exp_rd_q.pop_front();
               chk("rd_vld",   64'(usr_rd_vld),  64'(e.vld));
               chk("rd_data",  64'(usr_rd_data), 64'(e.data));
               chk("rd_cycle", 64'(cyc),         64'(e.cyc));
            end
         end
         if (arb_tmo) begin
            if (exp_tmo_q.size() == 0) unexpected("tmo_event", 64'(cyc));
            else chk("tmo_cycle", 64'(cyc), 64'(exp_tmo_q.pop_front()));
         end
         prev_busy = arb_busy;
         prev_ack  = usr_rd_ack;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   logic [11:0] rd_addr_tbl [4];
   logic [7:0]  rd_data_tbl [4];

   initial begin
      int n;
      rd_addr_tbl = '{12'h010, 12'h011, 12'h012, 12'h013};
      rd_data_tbl = '{8'h4A,   8'h4B,   8'h48,   8'h49};

      // Reset state
      tick();
      tick();
      @(negedge clk_sys);
      chk("rst_ack",   64'(usr_rd_ack),    64'h0);
      chk("rst_vld",   64'(usr_rd_vld),    64'h0);
      chk("rst_busy",  64'(arb_busy),      64'h0);
      chk("rst_gid",   64'(arb_grant_id),  64'h0);
      chk("rst_tmo",   64'(arb_tmo),       64'h0);
      chk("rst_rd_en", 64'(mux_ram_rd_en), 64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      // Single requester: user 2
      exp_grant_q.push_back(3'd2);
      exp_ack_q.push_back(4'b0100);
      usr_rd_req = 4'b0100;
      tick();
      @(negedge clk_sys);
      chk("single_busy",    64'(arb_busy),        64'h1);
      chk("single_ack_lat", 64'(usr_rd_ack),      64'h0);
      chk("single_addr",    64'(mux_ram_rd_addr), 64'h323);
      tick();
      usr_rd_done = 4'b0001;
      usr_rd_en   = 4'b0001;
      @(negedge clk_sys);
      chk("single_ack",      64'(usr_rd_ack),    64'b0100);
      chk("single_en_other", 64'(mux_ram_rd_en), 64'h0);
      tick();
      usr_rd_done = '0;
      usr_rd_en   = '0;
      @(negedge clk_sys);
      chk("single_done_other", 64'(arb_busy), 64'h1);
      tick();
      usr_rd_done = 4'b0100;
      usr_rd_req  = '0;
      tick();
      usr_rd_done = '0;
      @(negedge clk_sys);
      chk("single_release", 64'(arb_busy),   64'h0);
      chk("single_ack_off", 64'(usr_rd_ack), 64'h0);

      // Round robin: all four requesting
      do_reset();
      for (int i = 0; i < 5; i++) begin
         exp_grant_q.push_back(3'(i % 4));
         exp_ack_q.push_back(4'(4'b0001 << (i % 4)));
      end
      usr_rd_req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_ack("rr_ack_seen");
         repeat (4) tick();
         usr_rd_done = 4'(4'b0001 << (i % 4));
         if (i == 4) usr_rd_req = '0;
         tick();
         usr_rd_done = '0;
         @(negedge clk_sys);
         chk("rr_gap_low", 64'(arb_busy), 64'h0);
         if (i < 4) begin
            tick();
            @(negedge clk_sys);
            chk("rr_regrant", 64'(arb_busy), 64'h1);
         end
      end
      tick();

      // Read return, RD_LAT=2, user 1
      do_reset();
      exp_grant_q.push_back(3'd1);
      exp_ack_q.push_back(4'b0010);
      usr_rd_req = 4'b0010;
      wait_ack("rd_ack_seen");
      tick();
      for (int i = 0; i < 4; i++) begin
         usr_rd_addr[23:12] = rd_addr_tbl[i];
         usr_rd_en = 4'b0010;
         exp_rd_q.push_back('{vld: 4'b0010, data: rd_data_tbl[i], cyc: cyc + 2});
         if (i == 3) begin
            // last read is issued together with the release
            usr_rd_done = 4'b0010;
            usr_rd_req  = '0;
         end
         @(negedge clk_sys);
         chk("rd_mux_addr", 64'(mux_ram_rd_addr), 64'(rd_addr_tbl[i]));
         chk("rd_mux_en",   64'(mux_ram_rd_en),   64'h1);
         tick();
      end
      usr_rd_en   = '0;
      usr_rd_done = '0;
      repeat (4) tick();
      usr_rd_addr[23:12] = 12'h223;

      // Watchdog: user 3 never releases, user 1 waiting
      do_reset();
      exp_grant_q.push_back(3'd3);
      exp_grant_q.push_back(3'd1);
      exp_ack_q.push_back(4'b1000);
      exp_ack_q.push_back(4'b0010);
      n = cyc;
      exp_tmo_q.push_back(n + 17);
      usr_rd_req = 4'b1000;
      tick();
      usr_rd_req = 4'b1010;
      repeat (15) tick();
      @(negedge clk_sys);
      chk("wd_busy_last", 64'(arb_busy), 64'h1);
      chk("wd_tmo_early", 64'(arb_tmo),  64'h0);
      tick();
      @(negedge clk_sys);
      chk("wd_release", 64'(arb_busy), 64'h0);
      chk("wd_tmo",     64'(arb_tmo),  64'h1);
      tick();
      @(negedge clk_sys);
      chk("wd_next_busy",  64'(arb_busy),     64'h1);
      chk("wd_next_gid",   64'(arb_grant_id), 64'h1);
      chk("wd_ack3_drop",  64'(usr_rd_ack),   64'h0);
      chk("wd_tmo_single", 64'(arb_tmo),      64'h0);
      wait_ack("wd_ack1_seen");
      tick();
      usr_rd_done = 4'b0010;
      usr_rd_req  = '0;
      tick();
      usr_rd_done = '0;
      repeat (2) tick();

      // done on the final watchdog cycle
      do_reset();
      exp_grant_q.push_back(3'd3);
      exp_ack_q.push_back(4'b1000);
      usr_rd_req = 4'b1000;
      repeat (16) tick();
      usr_rd_done = 4'b1000;
      usr_rd_req  = '0;
      @(negedge clk_sys);
      chk("dt_busy_last", 64'(arb_busy), 64'h1);
      tick();
      usr_rd_done = '0;
      @(negedge clk_sys);
      chk("dt_release", 64'(arb_busy), 64'h0);
      chk("dt_no_tmo",  64'(arb_tmo),  64'h0);
      repeat (3) tick();

      // Asynchronous reset mid-RDRAM with reads in flight
      do_reset();
      exp_grant_q.push_back(3'd1);
      exp_ack_q.push_back(4'b0010);
      usr_rd_req = 4'b0010;
      wait_ack("ar_ack_seen");
      tick();
      usr_rd_en = 4'b0010;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_ack",   64'(usr_rd_ack),    64'h0);
      chk("ar_vld",   64'(usr_rd_vld),    64'h0);
      chk("ar_busy",  64'(arb_busy),      64'h0);
      chk("ar_gid",   64'(arb_grant_id),  64'h0);
      chk("ar_tmo",   64'(arb_tmo),       64'h0);
      chk("ar_rd_en", 64'(mux_ram_rd_en), 64'h0);
      usr_rd_en  = '0;
      usr_rd_req = 4'b1111;
      exp_grant_q.push_back(3'd0);
      exp_ack_q.push_back(4'b0001);
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk_sys);
      chk("ar_idle", 64'(arb_busy), 64'h0);
      tick();
      @(negedge clk_sys);
      chk("ar_arbit", 64'(arb_busy), 64'h0);
      tick();
      @(negedge clk_sys);
      chk("ar_busy_after", 64'(arb_busy),     64'h1);
      chk("ar_user0_prio", 64'(arb_grant_id), 64'h0);
      wait_ack("ar_ack_after");
      tick();
      usr_rd_done = 4'b0001;
      usr_rd_req  = '0;
      tick();
      usr_rd_done = '0;
      repeat (4) tick();

      chk("left_grant", 64'(exp_grant_q.size()), 64'h0);
      chk("left_ack",   64'(exp_ack_q.size()),   64'h0);
      chk("left_rd",    64'(exp_rd_q.size()),    64'h0);
      chk("left_tmo",   64'(exp_tmo_q.size()),   64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
